// File: rtl/spi_adc_responder.sv
// spi_adc_responder: emulates a multi-lane SAR ADC behind an SPI controller.
// Conversion frames stream sample words out on NUM_SDO lanes. Register frames
// access a small register file, and each register write is reported on an
// AXI-Stream master. SPI pins are oversampled on aclk; SCK is never a clock.
module spi_adc_responder #(
    parameter int NUM_SDO       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  spi_csn,
    input  logic                  spi_sck,
    input  logic                  spi_sdi,
    output logic [NUM_SDO-1:0]    spi_sdo,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  reg_mode,
    output logic                  frame_err,
    output logic [15:0]           underrun_cnt
);
    localparam logic [5:0] CONV_CLKS = 6'(DATA_WIDTH / NUM_SDO);
    localparam int         REG_DEPTH = 2 ** REG_ADDR_BITS;

    typedef enum logic {ST_CONV, ST_REG} state_t;
    state_t state, state_nxt;

    logic csn_p0, csn_p1, csn_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic sdi_p0, sdi_p1;
    logic in_frame;
    logic [5:0] bit_cnt;
    logic [23:0] sdi_sr;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic hold_valid;
    logic [7:0] rd_sr;
    logic [7:0] regfile [REG_DEPTH];
    logic reg_we, rpt_load, err_nxt;

    // Register frame fields as captured after 24 SCK rises.
    logic        wr_bit;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        addr_ok;
    logic        rd_addr_ok;
    logic        s_load;

    assign wr_bit     = sdi_sr[23];
    assign addr       = sdi_sr[22:8];
    assign wdata      = sdi_sr[7:0];
    assign addr_ok    = (addr[14:REG_ADDR_BITS] == '0);
    assign rd_addr_ok = (sdi_sr[14:REG_ADDR_BITS] == '0);
    assign s_load     = s_axis_tvalid & s_axis_tready;

    // CSn chain resets to 0 so a frame already active at reset release
    // never produces a CSn fall; only a real high-to-low transition starts one.
    logic csn_fall, csn_rise, sck_rise, sck_fall;
    assign csn_fall = csn_p2 & ~csn_p1;
    assign csn_rise = in_frame & ~csn_p2 & csn_p1;
    assign sck_rise = in_frame & ~csn_p1 & ~sck_p2 & sck_p1;
    assign sck_fall = in_frame & ~csn_p1 & sck_p2 & ~sck_p1;

    // Two-FF synchronisers plus one delay stage for edge detection.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            {csn_p0, csn_p1, csn_p2} <= 3'b000;
            {sck_p0, sck_p1, sck_p2} <= 3'b000;
            {sdi_p0, sdi_p1}         <= 2'b00;
        end else begin
            {csn_p0, csn_p1, csn_p2} <= {spi_csn, csn_p0, csn_p1};
            {sck_p0, sck_p1, sck_p2} <= {spi_sck, sck_p0, sck_p1};
            {sdi_p0, sdi_p1}         <= {spi_sdi, sdi_p0};
        end
    end

    // Frame tracking: active flag and saturating rise counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_frame <= 1'b0;
            bit_cnt  <= '0;
        end else if (csn_fall) begin
            in_frame <= 1'b1;
            bit_cnt  <= '0;
        end else if (csn_rise) begin
            in_frame <= 1'b0;
        end else if (sck_rise && bit_cnt != 6'd63) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Datapath shift registers: SDI capture, conversion word, read-back byte.
    always_ff @(posedge aclk) begin
        if (csn_fall) begin
            sdi_sr <= '0;
            rd_sr  <= '0;
            if (state == ST_CONV)
                tx_sr <= hold_valid ? hold_data : '0;
        end else begin
            if (sck_rise && bit_cnt < 6'd24)
                sdi_sr <= {sdi_sr[22:0], sdi_p1};
            if (sck_fall) begin
                tx_sr <= tx_sr << NUM_SDO;
                if (state == ST_REG && bit_cnt == 6'd16 && !sdi_sr[15])
                    rd_sr <= rd_addr_ok ? regfile[sdi_sr[REG_ADDR_BITS-1:0]] : 8'h00;
                else
                    rd_sr <= {rd_sr[6:0], 1'b0};
            end
        end
        if (s_load)
            hold_data <= s_axis_tdata;
    end

    // Holding register flag and underrun counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_valid   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (csn_fall && state == ST_CONV) begin
                hold_valid <= 1'b0;
                if (!hold_valid && underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (s_load)
                hold_valid <= 1'b1;
        end
    end

    assign s_axis_tready = ~hold_valid;

    // Mode state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_CONV;
        else          state <= state_nxt;
    end

    // End-of-frame decode: mode change, register write, report, error.
    always_comb begin
        state_nxt = state;
        reg_we    = 1'b0;
        rpt_load  = 1'b0;
        err_nxt   = 1'b0;
        if (csn_rise) begin
            case (state)
                ST_CONV: begin
                    if (bit_cnt >= 6'd24 && sdi_sr[23:21] == 3'b101)
                        state_nxt = ST_REG;
                    else if (bit_cnt < CONV_CLKS)
                        err_nxt = 1'b1;
                end
                ST_REG: begin
                    if (bit_cnt != 6'd24) begin
                        err_nxt = 1'b1;
                    end else if (wr_bit) begin
                        if (addr == 15'h0014 && wdata == 8'h01) begin
                            state_nxt = ST_CONV;
                        end else begin
                            reg_we = addr_ok;
                            if (!m_axis_tvalid) rpt_load = 1'b1;
                            else                err_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_CONV;
            endcase
        end
    end

    // Register file, write report and error pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            frame_err     <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) regfile[i] <= '0;
        end else begin
            frame_err <= err_nxt;
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (rpt_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {8'h00, sdi_sr};
            end
            if (reg_we)
                regfile[addr[REG_ADDR_BITS-1:0]] <= wdata;
        end
    end

    assign reg_mode = (state == ST_REG);

    // Lane drive: idle low outside a frame, read-back on lane 0 in REG mode.
    always_comb begin
        spi_sdo = '0;
        if (in_frame) begin
            if (state == ST_CONV) spi_sdo = tx_sr[DATA_WIDTH-1 -: NUM_SDO];
            else                  spi_sdo[0] = rd_sr[7];
        end
    end
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: drives SPI frames and AXI-Stream traffic and
// compares against a frame-level reference model of the ADC emulator.
module tb_spi_adc_responder;
    localparam int NUM_SDO = 4;
    localparam int DATA_WIDTH = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic spi_csn = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
    logic [NUM_SDO-1:0] spi_sdo;
    logic [DATA_WIDTH-1:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready = 1'b0;
    logic reg_mode, frame_err;
    logic [15:0] underrun_cnt;

    spi_adc_responder #(.NUM_SDO(NUM_SDO), .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_BITS(5)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .reg_mode(reg_mode), .frame_err(frame_err), .underrun_cnt(underrun_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;
    int err_seen = 0;

    // Reference model state.
    bit          m_hold_full;
    logic [31:0] m_hold;
    bit          m_reg;
    logic [7:0]  m_regs [32];
    int          m_under;
    bit          m_rpt_v;
    logic [31:0] m_rpt;
    int          m_err;

    always @(negedge aclk) if (frame_err === 1'b1) err_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hold_full = 0; m_hold = '0; m_reg = 0; m_under = 0;
        m_rpt_v = 0; m_rpt = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    endtask

    task automatic check_status();
        chk("reg_mode", reg_mode, m_reg);
        chk("underrun_cnt", underrun_cnt, m_under);
        chk("frame_err_count", err_seen, m_err);
        chk("m_tvalid", m_axis_tvalid, m_rpt_v);
        if (m_rpt_v) chk("m_tdata", m_axis_tdata, m_rpt);
        chk("s_tready", s_axis_tready, !m_hold_full);
    endtask

    task automatic push(input logic [31:0] w);
        chk("s_tready_before_push", s_axis_tready, 1'b1);
        @(negedge aclk);
        s_axis_tvalid = 1'b1; s_axis_tdata = w;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        m_hold_full = 1; m_hold = w;
        chk("s_tready_after_push", s_axis_tready, 1'b0);
    endtask

    task automatic drain();
        @(negedge aclk); m_axis_tready = 1'b1;
        @(negedge aclk); m_axis_tready = 1'b0;
        m_rpt_v = 0;
        chk("m_tvalid_drained", m_axis_tvalid, 1'b0);
    endtask

    // One complete SPI frame of nbits clocks; SDI carries sdi_word MSB first.
    task automatic spi_frame(input int nbits, input logic [23:0] sdi_word);
        bit conv;
        logic [31:0] conv_word;
        logic [14:0] a;
        logic [7:0] rd_byte, d;
        logic [3:0] exp_l;
        conv = !m_reg;
        conv_word = '0;
        a = sdi_word[22:8];
        d = sdi_word[7:0];
        rd_byte = (a < 32) ? m_regs[a[4:0]] : 8'h00;
        if (conv) begin
            if (m_hold_full) begin conv_word = m_hold; m_hold_full = 0; end
            else if (m_under < 65535) m_under++;
        end
        @(negedge aclk); spi_csn = 1'b0;
        repeat (6) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = (i < 24) ? sdi_word[23-i] : 1'b0;
            repeat (6) @(negedge aclk);
            if (conv)
                exp_l = (i < DATA_WIDTH/NUM_SDO) ? 4'(conv_word >> (DATA_WIDTH - NUM_SDO*(i+1))) : 4'h0;
            else
                exp_l = (i >= 16 && i <= 23 && !sdi_word[23]) ? {3'b000, rd_byte[23-i]} : 4'h0;
            chk("spi_sdo", spi_sdo, exp_l);
            spi_sck = 1'b1;
            repeat (6) @(negedge aclk);
            spi_sck = 1'b0;
        end
        repeat (6) @(negedge aclk); spi_csn = 1'b1; spi_sdi = 1'b0;
        repeat (8) @(negedge aclk);
        chk("spi_sdo_idle", spi_sdo, 4'h0);
        if (conv) begin
            if (nbits >= 24 && sdi_word[23:21] == 3'b101) m_reg = 1;
            else if (nbits < DATA_WIDTH/NUM_SDO) m_err++;
        end else begin
            if (nbits != 24) m_err++;
            else if (sdi_word[23]) begin
                if (a == 15'h0014 && d == 8'h01) m_reg = 0;
                else begin
                    if (a < 32) m_regs[a[4:0]] = d;
                    if (!m_rpt_v) begin m_rpt_v = 1; m_rpt = {8'h00, sdi_word}; end
                    else m_err++;
                end
            end
        end
        check_status();
    endtask

    initial begin
        int r;
        logic [14:0] ra;
        model_reset();
        m_err = 0;
        repeat (5) @(negedge aclk);
        chk("rst_sdo", spi_sdo, 4'h0);
        chk("rst_s_tready", s_axis_tready, 1'b1);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 32'h0);
        chk("rst_reg_mode", reg_mode, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_underrun", underrun_cnt, 16'h0);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);

        // Conversion word on four lanes, then an underrun frame.
        push(32'hDEADBEEF);
        spi_frame(8, 24'h000000);
        spi_frame(8, 24'h000000);
        // Enter register mode, write then read back.
        spi_frame(24, 24'hA00000);
        spi_frame(24, 24'h800355);
        spi_frame(24, 24'h000300);
        drain();
        // Two writes with no report acceptance, then exit.
        spi_frame(24, 24'h800355);
        spi_frame(24, 24'h800355);
        spi_frame(24, 24'h801401);
        // Short register frame, then back to conversion.
        spi_frame(24, 24'hA00000);
        spi_frame(10, 24'h8003AA);
        spi_frame(24, 24'h000300);
        spi_frame(24, 24'h801401);

        // Reset asserted mid-conversion frame; the interrupted frame is ignored.
        push(32'h12345678);
        @(negedge aclk); spi_csn = 1'b0;
        repeat (6) @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            spi_sck = 1'b1; repeat (6) @(negedge aclk);
            spi_sck = 1'b0; repeat (6) @(negedge aclk);
        end
        aresetn = 1'b0;
        #1;
        chk("arst_sdo", spi_sdo, 4'h0);
        chk("arst_s_tready", s_axis_tready, 1'b1);
        chk("arst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_m_tdata", m_axis_tdata, 32'h0);
        chk("arst_reg_mode", reg_mode, 1'b0);
        chk("arst_underrun", underrun_cnt, 16'h0);
        model_reset();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (6) @(negedge aclk);
            chk("post_rst_sdo", spi_sdo, 4'h0);
            spi_sck = 1'b1; repeat (6) @(negedge aclk);
            spi_sck = 1'b0;
        end
        repeat (6) @(negedge aclk); spi_csn = 1'b1;
        repeat (8) @(negedge aclk);
        check_status();
        // Register file cleared by reset.
        spi_frame(24, 24'hA00000);
        spi_frame(24, 24'h000300);

        // Randomized traffic.
        for (int it = 0; it < 50; it++) begin
            if (!m_reg) begin
                if (!m_hold_full && $urandom_range(0, 1) == 1) push($urandom);
                r = $urandom_range(0, 3);
                case (r)
                    0: spi_frame($urandom_range(1, 12), 24'($urandom));
                    1: spi_frame(8, 24'($urandom));
                    2: spi_frame($urandom_range(24, 30), {3'b101, 21'($urandom)});
                    default: spi_frame($urandom_range(9, 30), 24'($urandom));
                endcase
            end else begin
                if (m_rpt_v && $urandom_range(0, 2) == 0) drain();
                r = $urandom_range(0, 9);
                ra = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 31));
                if (r < 4)       spi_frame(24, {1'b1, ra, 8'($urandom)});
                else if (r < 7)  spi_frame(24, {1'b0, ra, 8'($urandom)});
                else if (r < 8)  spi_frame(24, 24'h801401);
                else             spi_frame($urandom_range(1, 30), 24'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
